// File: rtl/slice_alu_pkg.sv
// Shared types for the bit-sliced stream ALU: opcodes, sequencer states, slice-count helper.
package slice_alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'd0,
        ALU_SUB    = 3'd1,
        ALU_MUL_LO = 3'd2,
        ALU_MUL_HI = 3'd3,
        ALU_AND    = 3'd4,
        ALU_OR     = 3'd5,
        ALU_XOR    = 3'd6,
        ALU_RSVD   = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_MUL_IN,
        ST_MUL_EXEC,
        ST_MUL_OUT
    } alu_state_e;

    function automatic int calc_ns(input int length, input int slice);
        return length / slice;
    endfunction

endpackage

// File: rtl/slice_stream_alu_mac.sv
// One multiply step: full-width A times one SLICE-bit digit of B, shifted into place and accumulated.
module slice_mac #(
    parameter int LENGTH = 32,
    parameter int SLICE  = 4,
    parameter int IW     = 4
) (
    input  logic [2*LENGTH-1:0] acc,
    input  logic [LENGTH-1:0]   a,
    input  logic [SLICE-1:0]    b_slice,
    input  logic [IW-1:0]       idx,
    output logic [2*LENGTH-1:0] acc_next
);

    logic [LENGTH+SLICE-1:0] pp;
    logic [2*LENGTH-1:0]     pp_ext;

    assign pp       = {{SLICE{1'b0}}, a} * {{LENGTH{1'b0}}, b_slice};
    assign pp_ext   = {{(LENGTH-SLICE){1'b0}}, pp} << (idx * SLICE);
    assign acc_next = acc + pp_ext;

endmodule

// File: rtl/slice_stream_alu.sv
// Bit-sliced ALU: operands and results stream LSB slice first; multiply is buffered, then iterated per slice.
module slice_stream_alu
    import slice_alu_pkg::*;
#(
    parameter int LENGTH = 32,
    parameter int SLICE  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SLICE-1:0] rs1_d,
    input  logic [SLICE-1:0] rs2_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SLICE-1:0] rd_d,
    output logic             out_last,
    output logic             carry_out,
    output logic             busy
);

    localparam int NS = calc_ns(LENGTH, SLICE);
    localparam int CW = $clog2(NS + 1);
    localparam logic [CW-1:0] LAST = CW'(NS - 1);

    alu_state_e          state, state_nx;
    alu_op_e             op_q, op_in;
    logic [CW-1:0]       cnt;
    logic                carry;
    logic [LENGTH-1:0]   a_q, b_q;
    logic [2*LENGTH-1:0] acc, acc_nx;
    logic [LENGTH-1:0]   res_half;
    logic [SLICE:0]      sum;
    logic [SLICE-1:0]    slice_res;
    logic                slice_cout, arith, cnt_last, in_fire, out_fire;

    assign op_in    = alu_op_e'(op);
    assign busy     = (state != ST_IDLE);
    assign cnt_last = (cnt == LAST);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign arith    = (op_q == ALU_ADD) || (op_q == ALU_SUB);
    assign res_half = (op_q == ALU_MUL_HI) ? acc[2*LENGTH-1:LENGTH] : acc[LENGTH-1:0];

    // SUB reuses the adder: inverted rs2 plus a carry register seeded with 1 at start.
    assign sum = {1'b0, rs1_d} + {1'b0, (op_q == ALU_SUB) ? ~rs2_d : rs2_d}
               + {{SLICE{1'b0}}, carry};

    always_comb begin
        slice_res  = '0;
        slice_cout = 1'b0;
        case (op_q)
            ALU_ADD, ALU_SUB: begin
                slice_res  = sum[SLICE-1:0];
                slice_cout = sum[SLICE];
            end
            ALU_AND: slice_res = rs1_d & rs2_d;
            ALU_OR:  slice_res = rs1_d | rs2_d;
            ALU_XOR: slice_res = rs1_d ^ rs2_d;
            default: slice_res = '0;
        endcase
    end

    slice_mac #(.LENGTH(LENGTH), .SLICE(SLICE), .IW(CW)) u_mac (
        .acc      (acc),
        .a        (a_q),
        .b_slice  (b_q[cnt*SLICE +: SLICE]),
        .idx      (cnt),
        .acc_next (acc_nx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_nx = (op_in == ALU_MUL_LO || op_in == ALU_MUL_HI) ? ST_MUL_IN : ST_STREAM;
            end
            ST_STREAM: begin
                // Once the final slice is out, no further beat belongs to this operation.
                in_ready = (!out_valid || out_ready) && !(out_valid && out_last);
                if (out_fire && out_last) state_nx = ST_IDLE;
            end
            ST_MUL_IN: begin
                in_ready = 1'b1;
                if (in_fire && cnt_last) state_nx = ST_MUL_EXEC;
            end
            ST_MUL_EXEC: begin
                if (cnt_last) state_nx = ST_MUL_OUT;
            end
            ST_MUL_OUT: begin
                if (out_fire && out_last) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= ALU_ADD;
            cnt       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            rd_d      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= op_in;
                        cnt   <= '0;
                        carry <= (op_in == ALU_SUB);
                        acc   <= '0;
                    end
                end
                ST_STREAM: begin
                    if (out_fire) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        carry_out <= 1'b0;
                    end
                    if (in_fire) begin
                        rd_d      <= slice_res;
                        out_valid <= 1'b1;
                        out_last  <= cnt_last;
                        carry_out <= cnt_last && arith && slice_cout;
                        carry     <= slice_cout;
                        cnt       <= cnt + 1'b1;
                    end
                end
                ST_MUL_IN: begin
                    if (in_fire) begin
                        a_q <= {rs1_d, a_q[LENGTH-1:SLICE]};
                        b_q <= {rs2_d, b_q[LENGTH-1:SLICE]};
                        cnt <= cnt_last ? '0 : cnt + 1'b1;
                    end
                end
                ST_MUL_EXEC: begin
                    acc <= acc_nx;
                    cnt <= cnt_last ? '0 : cnt + 1'b1;
                end
                ST_MUL_OUT: begin
                    if (out_fire && out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end else if (!out_valid || out_ready) begin
                        rd_d      <= res_half[cnt*SLICE +: SLICE];
                        out_valid <= 1'b1;
                        out_last  <= cnt_last;
                        cnt       <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_slice_stream_alu.sv
// Directed bench for slice_stream_alu with a queue scoreboard of expected result slices.
module tb_slice_stream_alu;

    localparam int LEN = 32;
    localparam int SL  = 4;
    localparam int NS  = LEN / SL;

    typedef struct {
        logic [SL-1:0] d;
        logic          last;
        logic          c;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, in_valid, in_ready, out_valid, out_ready;
    logic          out_last, carry_out, busy;
    logic [2:0]    op;
    logic [SL-1:0] rs1_d, rs2_d, rd_d;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    slice_stream_alu #(.LENGTH(LEN), .SLICE(SL)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .in_valid(in_valid), .in_ready(in_ready), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .out_valid(out_valid), .out_ready(out_ready), .rd_d(rd_d),
        .out_last(out_last), .carry_out(carry_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: samples on the falling edge, when handshake signals are settled.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'(rd_d), 64'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rd_d", 64'(rd_d), 64'(e.d));
                check("out_last", 64'(out_last), 64'(e.last));
                check("carry_out", 64'(carry_out), 64'(e.c));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [2:0] o, input logic [LEN-1:0] a, input logic [LEN-1:0] b);
        logic [LEN:0]     s;
        logic [2*LEN-1:0] p;
        logic [LEN-1:0]   r;
        logic             c;
        p = 64'(a) * 64'(b);
        c = 1'b0;
        case (o)
            3'd0: begin s = 33'(a) + 33'(b); r = s[LEN-1:0]; c = s[LEN]; end
            3'd1: begin r = a - b; c = (a >= b); end
            3'd2: r = p[LEN-1:0];
            3'd3: r = p[2*LEN-1:LEN];
            3'd4: r = a & b;
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            default: r = '0;
        endcase
        for (int i = 0; i < NS; i++) begin
            exp_t e;
            e.d    = r[i*SL +: SL];
            e.last = (i == NS - 1);
            e.c    = (i == NS - 1) ? c : 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic start_op(input logic [2:0] o);
        start = 1'b1;
        op    = o;
        tick();
        start = 1'b0;
    endtask

    // Drives NS beats; optionally stalls the consumer for 3 cycles after beat stall_at is accepted.
    task automatic send_beats(input logic [LEN-1:0] a, input logic [LEN-1:0] b, input int stall_at);
        for (int i = 0; i < NS; i++) begin
            int guard;
            guard    = 0;
            rs1_d    = a[i*SL +: SL];
            rs2_d    = b[i*SL +: SL];
            in_valid = 1'b1;
            @(negedge clk);
            while (!in_ready && guard < 100) begin
                tick();
                @(negedge clk);
                guard++;
            end
            check("in_ready_beat", 64'(in_ready), 64'd1);
            tick();
            if (i == stall_at) begin
                logic [SL-1:0] held;
                out_ready = 1'b0;
                held      = rd_d;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    check("stall_rd_hold", 64'(rd_d), 64'(held));
                    check("stall_valid", 64'(out_valid), 64'd1);
                    tick();
                end
                out_ready = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 200) begin
            tick();
            guard++;
        end
        check("busy_falls", 64'(busy), 64'd0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [LEN-1:0] a, input logic [LEN-1:0] b);
        push_expected(o, a, b);
        start_op(o);
        send_beats(a, b, -1);
        wait_idle();
    endtask

    initial begin
        int n;
        reset = 1'b0; start = 1'b0; op = '0; in_valid = 1'b0;
        rs1_d = '0; rs2_d = '0; out_ready = 1'b1;
        #12;
        check("rst_rd_d", 64'(rd_d), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_carry_out", 64'(carry_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        run_op(3'd0, 32'hFFFFFFFF, 32'h00000001);
        run_op(3'd1, 32'h00000005, 32'h00000007);

        // Multiply with first-result latency measured from the first operand beat.
        push_expected(3'd2, 32'h12345678, 32'h00000010);
        start_op(3'd2);
        check("busy_after_start", 64'(busy), 64'd1);
        send_beats(32'h12345678, 32'h00000010, -1);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check("mul_latency", 64'(NS + n), 64'd17);
        wait_idle();
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);

        // Consumer stall after two slices have been taken.
        push_expected(3'd6, 32'hA5A5A5A5, 32'hFFFF0000);
        start_op(3'd6);
        send_beats(32'hA5A5A5A5, 32'hFFFF0000, 2);
        wait_idle();

        // Reset during MUL_EXEC abandons the multiply.
        start_op(3'd2);
        send_beats(32'hDEADBEEF, 32'h12345678, -1);
        tick(); tick(); tick();
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_rd_d", 64'(rd_d), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_out_last", 64'(out_last), 64'd0);
        check("midrst_carry_out", 64'(carry_out), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        run_op(3'd0, 32'h00000001, 32'h00000002);

        // in_valid while idle is not accepted and produces nothing.
        in_valid = 1'b1; rs1_d = 4'hF; rs2_d = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        in_valid = 1'b0;

        // start held high with a different op during an ADD.
        push_expected(3'd0, 32'h0F0F1234, 32'h01010101);
        start_op(3'd0);
        start = 1'b1;
        op    = 3'd1;
        send_beats(32'h0F0F1234, 32'h01010101, -1);
        start = 1'b0;
        wait_idle();

        run_op(3'd4, 32'hF0F0AAAA, 32'h3C3C5555);
        run_op(3'd5, 32'hF0F00000, 32'h0F0F1234);
        run_op(3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int k = 0; k < 4; k++) begin
            logic [LEN-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            run_op((k % 2 == 0) ? 3'd0 : 3'd1, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
